halt_dump_responder: RTL

Host-side responder for the processor18 halt handshake. When the processor raises `wait_for_continue`, this block takes over the data RAM port and reads the first `DUMP_WORDS` words. It streams them out over a valid/ready word interface, preceded by one header word. It then pulses `wait_continue_execution` to resume the core. It sits between `processor`, the data `ram` (through an external port mux driven by `mem_select`) and a host link such as a UART framer.

---
 rtl/halt_dump_responder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/halt_dump_responder.sv
// halt_dump_responder
//
// Host-side responder for the processor halt handshake. When the core raises
// wait_for_continue, this block takes over the data RAM read port, sends one
// header word (DUMP_WORDS), then streams RAM words 0..DUMP_WORDS-1 over a
// valid/ready word interface, and finally pulses wait_continue_execution to
// resume the core.
//
// Ports:
//   clock                    in   single clock, rising edge
//   reset                    in   synchronous, active-high
//   wait_for_continue        in   processor halt flag
//   wait_continue_execution  out  one-cycle resume pulse
//   mem_select               out  1 = RAM port owned by this block (read only)
//   mem_addr   [ADDR_SIZE]   out  RAM read address
//   mem_dout   [WORD_SIZE]   in   RAM read data, one cycle after mem_addr
//   out_valid                out  stream word valid
//   out_ready                in   stream sink ready
//   out_data   [WORD_SIZE]   out  stream word
//   host_continue            in   resume request (AUTO_CONTINUE = 0 only)
//   busy                     out  high whenever not IDLE
module halt_dump_responder #(
    parameter int ADDR_SIZE     = 18,
    parameter int WORD_SIZE     = 18,
    parameter int DUMP_WORDS    = 64,
    parameter int AUTO_CONTINUE = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wait_for_continue,
    output logic                 wait_continue_execution,
    output logic                 mem_select,
    output logic [ADDR_SIZE-1:0] mem_addr,
    input  logic [WORD_SIZE-1:0] mem_dout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_data,
    input  logic                 host_continue,
    output logic                 busy
);

    localparam logic [ADDR_SIZE-1:0] LAST_INDEX  = ADDR_SIZE'(DUMP_WORDS - 1);
    localparam logic [WORD_SIZE-1:0] HEADER_WORD = WORD_SIZE'(DUMP_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        FETCH,
        LATCH,
        SEND,
        DONE,
        RESUME,
        DRAIN
    } state_t;

    state_t                 state_reg, state_next;
    logic [ADDR_SIZE-1:0]   i_reg, i_next;
    logic [WORD_SIZE-1:0]   data_reg, data_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            i_reg     <= '0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            i_reg     <= i_next;
            data_reg  <= data_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        i_next     = i_reg;
        data_next  = data_reg;
        case (state_reg)
            IDLE: begin
                i_next = '0;
                if (wait_for_continue) begin
                    // The header word is loaded into the output register on
                    // the way in, so out_data stays a pure register output.
                    data_next  = HEADER_WORD;
                    state_next = HEADER;
                end
            end
            HEADER: begin
                if (out_ready) state_next = FETCH;
            end
            FETCH: begin
                state_next = LATCH;
            end
            LATCH: begin
                // RAM read data is valid now, one cycle after the address.
                data_next  = mem_dout;
                state_next = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    if (i_reg == LAST_INDEX) begin
                        state_next = DONE;
                    end else begin
                        i_next     = i_reg + 1'b1;
                        state_next = FETCH;
                    end
                end
            end
            DONE: begin
                if (AUTO_CONTINUE != 0 || host_continue) state_next = RESUME;
            end
            RESUME: begin
                state_next = DRAIN;
            end
            DRAIN: begin
                // Wait for the halt flag to drop so one halt yields one dump.
                if (!wait_for_continue) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Every output is either a register or decoded from the state register.
    assign mem_select              = (state_reg == FETCH) || (state_reg == LATCH) ||
                                     (state_reg == SEND);
    assign mem_addr                = i_reg;
    assign out_valid               = (state_reg == HEADER) || (state_reg == SEND);
    assign out_data                = data_reg;
    assign wait_continue_execution = (state_reg == RESUME);
    assign busy                    = (state_reg != IDLE);

endmodule
